load_store_unit: RTL and testbench

//  Initiator side of the word-wide data memory interface. Accepts load/store requests from the CPU datapath,

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator for the word-addressed data memory
// Byte/half/word loads with sign or zero extension; sub-word stores are done as read-modify-write.
// Optional build macro LSU_PERF_CNT_EN adds saturating load/store/error response counters.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;     // only the low half is ever needed for merges
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] rdata_q;
  logic        mem_write_q;
  logic [31:0] mem_wdata_q;

  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Request validation, lane extraction from the read word, and store lane merge
  always_comb begin
    req_err = (req_size == SZ_RSVD)
            | ((req_size == SZ_HALF) & req_addr[0])
            | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
            | ({2'b00, req_addr[31:2]} >= MEM_WORDS);

    case (addr_q[1:0])
      2'd0:    rd_byte = mem_read_data[7:0];
      2'd1:    rd_byte = mem_read_data[15:8];
      2'd2:    rd_byte = mem_read_data[23:16];
      default: rd_byte = mem_read_data[31:24];
    endcase
    rd_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_data = mem_read_data;
    endcase

    merged = mem_read_data;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Request/response sequencer: accept in IDLE, optional read, optional single write, hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            signed_q   <= req_signed;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata[15:0];
            rdata_q    <= 32'd0;
            resp_err_q <= req_err;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (req_write && (req_size == SZ_WORD)) begin
              mem_wdata_q <= req_wdata;
              mem_write_q <= 1'b1;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!write_q) begin
            rdata_q      <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            mem_wdata_q <= merged;
            mem_write_q <= 1'b1;
            state_q     <= S_WR;
          end
        end
        S_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = rdata_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = mem_wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_cnt_q;
  logic [15:0] store_cnt_q;
  logic [15:0] err_cnt_q;
  logic        resp_fire;

  assign resp_fire = (state_q == S_RESP) && resp_ready;

  // Saturating per-kind counters, bumped once per completed response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= 16'd0;
      store_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else if (resp_fire) begin
      if (resp_err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (write_q) begin
        if (store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
      end else begin
        if (load_cnt_q != 16'hFFFF) load_cnt_q <= load_cnt_q + 16'd1;
      end
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef LSU_PERF_CNT_EN
    ,
    .load_cnt       (load_cnt),
    .store_cnt      (store_cnt),
    .err_cnt        (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_wr,
                              input logic chk_mem, input logic [31:0] exp_mem);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    v.chk_mem = chk_mem; v.exp_mem = exp_mem;
    return v;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  task automatic do_req(input string nm, input vec_t v);
    int lat;
    int wcnt;
    logic [31:0] rd;
    logic er;
    lat = 0; wcnt = 0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    drive_req(v);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_write) wcnt++;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    check_int({nm, " latency"}, lat, v.exp_lat);
    check32({nm, " rdata"}, rd, v.exp_rdata);
    check32({nm, " err"}, {31'd0, er}, {31'd0, v.exp_err});
    check_int({nm, " write pulses"}, wcnt, v.exp_wr);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check32({nm, " resp_valid after handshake"}, {31'd0, resp_valid}, 32'd0);
    check32({nm, " req_ready after handshake"}, {31'd0, req_ready}, 32'd1);
    check32({nm, " mem_write after handshake"}, {31'd0, mem_write}, 32'd0);
    if (v.chk_mem) check32({nm, " memory word"}, mem[v.addr[11:2]], v.exp_mem);
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

    //       wr    size   sgn   addr          wdata         exp_rdata     err   lat wr chk   exp_mem
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1, 1'b1, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1, 1'b1, 32'h1122_3344));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h0000_0000, 1'b0, 3, 1, 1'b1, 32'h1122_A544));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'hFFFF_FFA5, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0000, 32'h0000_00A5, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'h0000_1122, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 3, 1, 1'b1, 32'hBEEF_A544));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_BEEF, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_BEEF, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FFBE, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0044, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hFFFF_FF7F, 32'h0000_0000, 1'b0, 3, 1, 1'b1, 32'h7FEF_A544));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_A544, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h7FEF_A544, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 1'b1, 32'h7FEF_A544));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h5555_5555, 32'h0000_0000, 1'b1, 1, 0, 1'b1, 32'h7FEF_A544));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 2, 1, 1'b1, 32'hCAFE_F00D));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2, 0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0FFF, 32'h0000_0000, 32'hFFFF_FFCA, 1'b0, 2, 0, 1'b0, 32'h0));

    // Reset state
    #12;
    check32("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("reset resp_err", {31'd0, resp_err}, 32'd0);
    check32("reset mem_write", {31'd0, mem_write}, 32'd0);
    check32("reset resp_rdata", resp_rdata, 32'd0);
    check32("reset mem_address", mem_address, 32'd0);
    check32("reset req_ready", {31'd0, req_ready}, 32'd1);
`ifdef LSU_PERF_CNT_EN
    check32("reset counters", {16'd0, load_cnt | store_cnt | err_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req($sformatf("vec%0d", i), vecs[i]);

    // Response back-pressure with a competing request held on the input
    @(negedge clk);
    v = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 2, 0, 1'b0, 32'h0);
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0000_0FFC;
    @(negedge clk);
    check32("stall first resp_valid", {31'd0, resp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32($sformatf("stall%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
      check32($sformatf("stall%0d rdata", k), resp_rdata, 32'h7FEF_A544);
      check32($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check32("stall exit resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("stall exit req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check32("stall nothing queued", {30'd0, resp_valid, mem_write}, 32'd0);
    check32("stall nothing queued ready", {31'd0, req_ready}, 32'd1);

    // Reset asserted while the word store is in its write cycle
    @(negedge clk);
    v = mk(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 1'b0, 32'h0);
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check32("wr cycle mem_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("mid reset mem_write", {31'd0, mem_write}, 32'd0);
    check32("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("mid reset mem_address", mem_address, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check32("post reset req_ready", {31'd0, req_ready}, 32'd1);
    check32("post reset resp_valid", {31'd0, resp_valid}, 32'd0);
    do_req("post reset load", mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h7FEF_A544, 1'b0, 2, 0, 1'b0, 32'h0));

`ifdef LSU_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check32("perf cleared load", {16'd0, load_cnt}, 32'd0);
    do_req("perf ld0", mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h7FEF_A544, 1'b0, 2, 0, 1'b0, 32'h0));
    do_req("perf st0", mk(1'b1, 2'b10, 1'b0, 32'h40, 32'h1, 32'h0, 1'b0, 2, 1, 1'b1, 32'h1));
    do_req("perf ld1", mk(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h1, 1'b0, 2, 0, 1'b0, 32'h0));
    do_req("perf er0", mk(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0));
    do_req("perf st1", mk(1'b1, 2'b00, 1'b0, 32'h41, 32'h2, 32'h0, 1'b0, 3, 1, 1'b1, 32'h201));
    do_req("perf ld2", mk(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h201, 1'b0, 2, 0, 1'b0, 32'h0));
    check32("perf load_cnt", {16'd0, load_cnt}, 32'd3);
    check32("perf store_cnt", {16'd0, store_cnt}, 32'd2);
    check32("perf err_cnt", {16'd0, err_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("perf reset load_cnt", {16'd0, load_cnt}, 32'd0);
    check32("perf reset store_cnt", {16'd0, store_cnt}, 32'd0);
    check32("perf reset err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors + 1, n_checks);
    $fatal(1);
  end

endmodule
